// File: rtl/alu_result_stage.sv
// ALU result stage: selects the function-unit result and queues {result, zero, overflow, illegal} in a 2-entry FIFO.
// Optional macro ALU_OVERFLOW_DETECT_EN enables signed overflow detection for ADD/SUB and overflow-corrected SLT.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] and_circ,
  input  logic [WIDTH-1:0] or_circ,
  input  logic [WIDTH-1:0] add_circ,
  input  logic [WIDTH-1:0] sub_circ,
  input  logic [2:0]       alu_ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] selResult;
  logic             selZero;
  logic             selIllegal;
  logic             sltBit;

  logic [WIDTH-1:0] resultMem [2];
  logic [1:0]       zeroMem;
  logic [1:0]       illegalMem;
  logic [1:0]       countReg;
  logic             wrPtrReg;
  logic             rdPtrReg;
  logic             push;
  logic             pop;

`ifdef ALU_OVERFLOW_DETECT_EN
  logic       addOvf;
  logic       subOvf;
  logic       selOvf;
  logic [1:0] ovfMem;

  assign addOvf = (a[MSB] == b[MSB]) && (add_circ[MSB] != a[MSB]);
  assign subOvf = (a[MSB] != b[MSB]) && (sub_circ[MSB] != a[MSB]);
  assign selOvf = ((alu_ctrl == 3'b010) && addOvf) || ((alu_ctrl == 3'b110) && subOvf);
  // SLT must reflect the true signed comparison even when the subtraction wraps.
  assign sltBit = sub_circ[MSB] ^ subOvf;
`else
  logic unusedOperands;

  assign unusedOperands = ^{a, b};
  assign sltBit         = sub_circ[MSB];
`endif

  always_comb begin
    selResult  = '0;
    selIllegal = 1'b0;
    case (alu_ctrl)
      3'b000:  selResult = and_circ;
      3'b001:  selResult = or_circ;
      3'b010:  selResult = add_circ;
      3'b110:  selResult = sub_circ;
      3'b111:  selResult = {{(WIDTH-1){1'b0}}, sltBit};
      default: selIllegal = 1'b1;
    endcase
  end

  assign selZero = (selResult == '0);

  // Handshake uses only registered occupancy, so in_ready never sees out_ready.
  assign in_ready  = (countReg != 2'd2);
  assign out_valid = (countReg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) resultMem[i] <= '0;
      zeroMem    <= '0;
      illegalMem <= '0;
    end else if (push) begin
      resultMem[wrPtrReg]  <= selResult;
      zeroMem[wrPtrReg]    <= selZero;
      illegalMem[wrPtrReg] <= selIllegal;
    end
  end

`ifdef ALU_OVERFLOW_DETECT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     ovfMem <= '0;
    else if (push) ovfMem[wrPtrReg] <= selOvf;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      countReg <= 2'd0;
      wrPtrReg <= 1'b0;
      rdPtrReg <= 1'b0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + 1'b1;
      if (pop)  rdPtrReg <= rdPtrReg + 1'b1;
      case ({push, pop})
        2'b10:   countReg <= countReg + 2'd1;
        2'b01:   countReg <= countReg - 2'd1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Head entry is gated by out_valid so the fields read zero whenever the queue is empty.
  assign alu_out = out_valid ? resultMem[rdPtrReg] : '0;
  assign zero    = out_valid & zeroMem[rdPtrReg];
  assign illegal = out_valid & illegalMem[rdPtrReg];
`ifdef ALU_OVERFLOW_DETECT_EN
  assign overflow = out_valid & ovfMem[rdPtrReg];
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed cases plus a randomized stream against a queue model.
module tb_alu_result_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] and_circ, or_circ, add_circ, sub_circ;
  logic [2:0]  alu_ctrl = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_out;
  logic        zero, overflow, illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
  } entry_t;

  entry_t model[$];

  always #5 clock = ~clock;

  // The function units are modelled as ideal arithmetic on a and b.
  assign and_circ = a & b;
  assign or_circ  = a | b;
  assign add_circ = a + b;
  assign sub_circ = a - b;

  alu_result_stage #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .and_circ (and_circ),
    .or_circ  (or_circ),
    .add_circ (add_circ),
    .sub_circ (sub_circ),
    .alu_ctrl (alu_ctrl),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .zero     (zero),
    .overflow (overflow),
    .illegal  (illegal)
  );

  // Reference: signed behaviour from wide integer arithmetic rather than sign-bit rules.
  function automatic entry_t refOp(input logic [2:0] c, input logic [31:0] av, input logic [31:0] bv);
    entry_t e;
    longint sa, sb, sum, dif;
    logic [31:0] d;
    bit ovfA, ovfS, slt;
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    sum  = sa + sb;
    dif  = sa - sb;
    d    = av - bv;
    ovfA = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
    ovfS = (dif > 64'sd2147483647) || (dif < -64'sd2147483648);
`ifdef ALU_OVERFLOW_DETECT_EN
    slt = (sa < sb);
`else
    slt  = d[31];
    ovfA = 1'b0;
    ovfS = 1'b0;
`endif
    e = '0;
    case (c)
      3'b000:  e.res = av & bv;
      3'b001:  e.res = av | bv;
      3'b010:  begin e.res = av + bv; e.o = ovfA; end
      3'b110:  begin e.res = av - bv; e.o = ovfS; end
      3'b111:  e.res = {31'd0, slt};
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic drive(input logic [2:0] c, input logic [31:0] av, input logic [31:0] bv,
                       input logic v, input logic r);
    alu_ctrl  = c;
    a         = av;
    b         = bv;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic drain();
    @(negedge clock);
    drive(3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty out_valid=%b expected=0", out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_out !== 32'd0 || zero !== 1'b0 || overflow !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b out=%h z=%b o=%b il=%b expected all 0",
               out_valid, alu_out, zero, overflow, illegal);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_and();
    @(negedge clock);
    drive(3'b000, 32'hF0F0_FFFF, 32'hFFFF_0000, 1'b1, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'hF0F0_0000 || zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL and_result valid=%b out=%h z=%b il=%b expected 1/f0f00000/0/0",
               out_valid, alu_out, zero, illegal);
    end
    $display("txn and out=%h", alu_out);
    drain();
  endtask

  task automatic test_sub_overflow();
    logic expOvf;
`ifdef ALU_OVERFLOW_DETECT_EN
    expOvf = 1'b1;
`else
    expOvf = 1'b0;
`endif
    @(negedge clock);
    drive(3'b110, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'h7FFF_FFFF || overflow !== expOvf) begin
      errors++;
      $display("FAIL sub_overflow valid=%b out=%h ovf=%b expected 1/7fffffff/%b",
               out_valid, alu_out, overflow, expOvf);
    end
    $display("txn sub out=%h ovf=%b", alu_out, overflow);
    drain();
  endtask

  task automatic test_slt();
    @(negedge clock);
    drive(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'h0000_0001 || zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_result valid=%b out=%h z=%b expected 1/00000001/0", out_valid, alu_out, zero);
    end
    $display("txn slt out=%h", alu_out);
    drain();
  endtask

  task automatic test_illegal();
    @(negedge clock);
    drive(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'd0 || zero !== 1'b1 || illegal !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL illegal_code valid=%b out=%h z=%b il=%b o=%b expected 1/0/1/1/0",
               out_valid, alu_out, zero, illegal, overflow);
    end
    $display("txn illegal out=%h il=%b", alu_out, illegal);
    drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    drive(3'b001, 32'd1, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    drive(3'b001, 32'd2, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_out !== 32'd1) begin
      errors++;
      $display("FAIL b2b_full in_ready=%b valid=%b out=%h expected 0/1/1", in_ready, out_valid, alu_out);
    end
    drive(3'b001, 32'd3, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (alu_out !== 32'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold out=%h in_ready=%b expected 1/0", alu_out, in_ready);
    end
    drive(3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second valid=%b out=%h in_ready=%b expected 1/2/1", out_valid, alu_out, in_ready);
    end
    $display("txn b2b head=%h", alu_out);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_third_dropped out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clock);
    drive(3'b010, $urandom | 32'h1, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    drive(3'b001, $urandom, 32'd5, 1'b1, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fill valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_out !== 32'd0) begin
      errors++;
      $display("FAIL midreset_clear valid=%b out=%h expected 0/0", out_valid, alu_out);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release in_ready=%b valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    entry_t exp;
    entry_t head;
    logic [31:0] ra, rb;
    bit doPush, doPop;
    model.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== (model.size() > 0) || in_ready !== (model.size() < 2)) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d valid=%b in_ready=%b expected %b/%b",
                 cyc, out_valid, in_ready, model.size() > 0, model.size() < 2);
      end
      if (model.size() > 0) begin
        head = model[0];
        checks++;
        if (alu_out !== head.res || zero !== head.z || overflow !== head.o || illegal !== head.il) begin
          errors++;
          $display("FAIL rand_head cyc=%0d out=%h z=%b o=%b il=%b expected %h/%b/%b/%b",
                   cyc, alu_out, zero, overflow, illegal, head.res, head.z, head.o, head.il);
        end
      end
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      drive(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      exp    = refOp(alu_ctrl, ra, rb);
      doPush = in_valid && (model.size() < 2);
      doPop  = out_ready && (model.size() > 0);
      @(posedge clock);
      if (doPop) begin
        head = model.pop_front();
        $display("txn pop out=%h z=%b o=%b il=%b", head.res, head.z, head.o, head.il);
      end
      if (doPush) model.push_back(exp);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_and();
    test_sub_overflow();
    test_slt();
    test_illegal();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
